// File: rtl/tpu_pkg.sv
// Shared FSM encoding, default sizes and the accumulator-width rule for the
// streaming matrix multiplier.
package tpu_pkg;

  localparam int TPU_SIZE       = 4;
  localparam int TPU_DATA_WIDTH = 8;
  localparam int TPU_ACC_WIDTH  = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_LOAD_B  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DRAIN   = 3'd4
  } tpu_state_e;

  // Full-range products summed over SIZE terms plus a sign bit must fit.
  function automatic int min_acc_width(input int data_width, input int size);
    return 2 * data_width + $clog2(size) + 1;
  endfunction

endpackage

// File: rtl/tpu_mac_cell.sv
// One multiply-accumulate cell: sign/zero-extend both operands, multiply, and
// add into a wrapping accumulator. APPROX_MULT_EN zeroes APPROX_DROP operand LSBs.
module tpu_mac_cell
  import tpu_pkg::*;
#(
  parameter int DATA_WIDTH  = TPU_DATA_WIDTH,
  parameter int ACC_WIDTH   = TPU_ACC_WIDTH,
  parameter int APPROX_DROP = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  en,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);

  localparam int PW = 2 * DATA_WIDTH + 2;
  localparam logic [DATA_WIDTH-1:0] KEEP_MASK = {DATA_WIDTH{1'b1}} << APPROX_DROP;

`ifdef APPROX_MULT_EN
  localparam logic APPROX_ON = 1'b1;
`else
  localparam logic APPROX_ON = 1'b0;
`endif

  logic [DATA_WIDTH-1:0]        a_op;
  logic [DATA_WIDTH-1:0]        b_op;
  logic signed [DATA_WIDTH:0]   a_ext;
  logic signed [DATA_WIDTH:0]   b_ext;
  logic signed [PW-1:0]         a_wide;
  logic signed [PW-1:0]         b_wide;
  logic signed [PW-1:0]         prod;
  logic signed [ACC_WIDTH-1:0]  prod_acc;

  assign a_op = APPROX_ON ? (a & KEEP_MASK) : a;
  assign b_op = APPROX_ON ? (b & KEEP_MASK) : b;

  // One extra bit lets a single signed multiplier serve both operand modes.
  assign a_ext    = {is_signed & a_op[DATA_WIDTH-1], a_op};
  assign b_ext    = {is_signed & b_op[DATA_WIDTH-1], b_op};
  assign a_wide   = PW'(a_ext);
  assign b_wide   = PW'(b_ext);
  assign prod     = a_wide * b_wide;
  assign prod_acc = ACC_WIDTH'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_acc;
    end
  end

endmodule

// File: rtl/tpu_matmul_stream.sv
// Streaming C = A x B with runtime M/K/N up to SIZE over a SIZE x SIZE MAC array.
// Optional build macro APPROX_MULT_EN selects truncated-operand multipliers.
module tpu_matmul_stream
  import tpu_pkg::*;
#(
  parameter int SIZE        = TPU_SIZE,
  parameter int DATA_WIDTH  = TPU_DATA_WIDTH,
  parameter int ACC_WIDTH   = TPU_ACC_WIDTH,
  parameter int APPROX_DROP = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            cfg_m,
  input  logic [7:0]            cfg_k,
  input  logic [7:0]            cfg_n,
  input  logic                  cfg_signed,
  input  logic                  cfg_accumulate,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  c_valid,
  input  logic                  c_ready,
  output logic [ACC_WIDTH-1:0]  c_data,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_error,
  output logic [2:0]            state_dbg
);

  localparam logic [2:0] IDLE    = ST_IDLE;
  localparam logic [2:0] LOAD_A  = ST_LOAD_A;
  localparam logic [2:0] LOAD_B  = ST_LOAD_B;
  localparam logic [2:0] COMPUTE = ST_COMPUTE;
  localparam logic [2:0] DRAIN   = ST_DRAIN;

  localparam int         IW     = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [7:0] SIZE_B = 8'(SIZE);

  if (ACC_WIDTH < min_acc_width(DATA_WIDTH, SIZE)) begin : g_acc_width_check
    $error("ACC_WIDTH is below the minimum for DATA_WIDTH and SIZE");
  end

  logic [2:0]            state_q;
  logic [7:0]            m_q, k_q, n_q;
  logic                  signed_q;
  logic [7:0]            row_q, col_q, kc_q;
  logic                  done_q, cfg_error_q;
  logic [DATA_WIDTH-1:0] a_buf [SIZE][SIZE];
  logic [DATA_WIDTH-1:0] b_buf [SIZE][SIZE];
  logic [ACC_WIDTH-1:0]  acc   [SIZE][SIZE];

  logic       dims_bad, start_ok, acc_clear;
  logic       a_fire, b_fire, c_fire, step;
  logic [7:0] row_lim, col_lim;
  logic       row_last, col_last, k_last;
  logic [IW-1:0] row_idx, col_idx, kc_idx;

  // Valid/ready: a beat transfers on the rising edge where valid & ready are
  // both high; the producer holds data stable while valid is high and ready low.
  assign a_ready = (state_q == LOAD_A);
  assign b_ready = (state_q == LOAD_B);
  assign c_valid = (state_q == DRAIN);
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign cfg_error = cfg_error_q;
  assign state_dbg = state_q;

  assign a_fire = a_valid & a_ready;
  assign b_fire = b_valid & b_ready;
  assign c_fire = c_valid & c_ready;
  assign step   = a_fire | b_fire | c_fire;

  assign dims_bad = (cfg_m == 8'd0) | (cfg_m > SIZE_B) |
                    (cfg_k == 8'd0) | (cfg_k > SIZE_B) |
                    (cfg_n == 8'd0) | (cfg_n > SIZE_B);
  assign start_ok  = (state_q == IDLE) & start & ~dims_bad;
  assign acc_clear = start_ok & ~cfg_accumulate;

  always_comb begin
    row_lim = m_q;
    col_lim = n_q;
    case (state_q)
      LOAD_A:  begin row_lim = m_q; col_lim = k_q; end
      LOAD_B:  begin row_lim = k_q; col_lim = n_q; end
      default: begin row_lim = m_q; col_lim = n_q; end
    endcase
  end

  assign row_last = (row_q == row_lim - 8'd1);
  assign col_last = (col_q == col_lim - 8'd1);
  assign k_last   = (kc_q == k_q - 8'd1);
  assign row_idx  = row_q[IW-1:0];
  assign col_idx  = col_q[IW-1:0];
  assign kc_idx   = kc_q[IW-1:0];

  assign c_data = c_valid ? acc[row_idx][col_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      m_q         <= '0;
      k_q         <= '0;
      n_q         <= '0;
      signed_q    <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      kc_q        <= '0;
      done_q      <= 1'b0;
      cfg_error_q <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        for (int j = 0; j < SIZE; j++) begin
          a_buf[i][j] <= '0;
          b_buf[i][j] <= '0;
        end
      end
    end else begin
      done_q      <= 1'b0;
      cfg_error_q <= 1'b0;

      // Shared row/column walker for both load streams and the drain.
      if (step) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? 8'd0 : row_q + 8'd1;
        end else begin
          col_q <= col_q + 8'd1;
        end
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            if (dims_bad) begin
              cfg_error_q <= 1'b1;
            end else begin
              m_q      <= cfg_m;
              k_q      <= cfg_k;
              n_q      <= cfg_n;
              signed_q <= cfg_signed;
              row_q    <= '0;
              col_q    <= '0;
              kc_q     <= '0;
              for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                  a_buf[i][j] <= '0;
                  b_buf[i][j] <= '0;
                end
              end
              state_q <= LOAD_A;
            end
          end
        end
        LOAD_A: begin
          if (a_fire) begin
            a_buf[row_idx][col_idx] <= a_data;
            if (row_last && col_last) state_q <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (b_fire) begin
            b_buf[row_idx][col_idx] <= b_data;
            if (row_last && col_last) state_q <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (k_last) begin
            kc_q    <= '0;
            state_q <= DRAIN;
          end else begin
            kc_q <= kc_q + 8'd1;
          end
        end
        DRAIN: begin
          if (c_fire && row_last && col_last) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Cells outside the active M x N window hold their values for later tiles.
  for (genvar i = 0; i < SIZE; i++) begin : g_row
    for (genvar j = 0; j < SIZE; j++) begin : g_col
      logic cell_en;
      assign cell_en = (state_q == COMPUTE) && (8'(i) < m_q) && (8'(j) < n_q);

      tpu_mac_cell #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH),
        .APPROX_DROP (APPROX_DROP)
      ) u_cell (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (acc_clear),
        .en        (cell_en),
        .is_signed (signed_q),
        .a         (a_buf[i][kc_idx]),
        .b         (b_buf[kc_idx][j]),
        .acc       (acc[i][j])
      );
    end
  end

endmodule

// File: tb/tb_tpu_matmul_stream.sv
// Directed and randomised jobs for tpu_matmul_stream with a model-fed
// expected-result queue; honours APPROX_MULT_EN in its reference model.
module tb_tpu_matmul_stream;

  localparam int SIZE = 4;
  localparam int DW   = 8;
  localparam int AW   = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    cfg_m, cfg_k, cfg_n;
  logic          cfg_signed, cfg_accumulate;
  logic          a_valid, a_ready;
  logic [DW-1:0] a_data;
  logic          b_valid, b_ready;
  logic [DW-1:0] b_data;
  logic          c_valid, c_ready;
  logic [AW-1:0] c_data;
  logic          busy, done, cfg_error;
  logic [2:0]    state_dbg;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int start_cyc;

  logic [DW-1:0] a_vals[$];
  logic [DW-1:0] b_vals[$];
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] acc_m [SIZE][SIZE];

  tpu_matmul_stream #(.SIZE(SIZE), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .APPROX_DROP(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_m          (cfg_m),
    .cfg_k          (cfg_k),
    .cfg_n          (cfg_n),
    .cfg_signed     (cfg_signed),
    .cfg_accumulate (cfg_accumulate),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_data         (a_data),
    .b_valid        (b_valid),
    .b_ready        (b_ready),
    .b_data         (b_data),
    .c_valid        (c_valid),
    .c_ready        (c_ready),
    .c_data         (c_data),
    .busy           (busy),
    .done           (done),
    .cfg_error      (cfg_error),
    .state_dbg      (state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] ext(input logic [DW-1:0] x, input bit sgn);
    logic [DW-1:0] v;
    v = x;
`ifdef APPROX_MULT_EN
    v[1:0] = 2'b00;
`endif
    return sgn ? {{(AW-DW){v[DW-1]}}, v} : {{(AW-DW){1'b0}}, v};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) acc_m[i][j] = '0;
  endtask

  task automatic build_expected(input int m, input int k, input int n, input bit sgn, input bit accum);
    if (!accum) clear_model();
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < n; j++) begin
        for (int kk = 0; kk < k; kk++)
          acc_m[i][j] = acc_m[i][j] + AW'(ext(a_vals[i*k+kk], sgn) * ext(b_vals[kk*n+j], sgn));
        exp_q.push_back(acc_m[i][j]);
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_a_ready"}, AW'(a_ready), 0);
    check({tag, "_b_ready"}, AW'(b_ready), 0);
    check({tag, "_c_valid"}, AW'(c_valid), 0);
    check({tag, "_c_data"}, c_data, 0);
    check({tag, "_busy"}, AW'(busy), 0);
    check({tag, "_done"}, AW'(done), 0);
    check({tag, "_cfg_error"}, AW'(cfg_error), 0);
  endtask

  // Driver tasks: all called at a negedge and return at a negedge.
  task automatic do_start(input int m, input int k, input int n, input bit sgn, input bit accum);
    cfg_m = 8'(m); cfg_k = 8'(k); cfg_n = 8'(n);
    cfg_signed = sgn; cfg_accumulate = accum;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed_a(input string tag);
    int guard;
    for (int e = 0; e < a_vals.size(); e++) begin
      a_data = a_vals[e];
      a_valid = 1'b1;
      guard = 0;
      while (!a_ready && guard < 200) begin @(negedge clk); guard++; end
      if (!a_ready) begin check({tag, "_a_ready_timeout"}, AW'(a_ready), 1); break; end
      @(negedge clk);
    end
    a_valid = 1'b0;
  endtask

  task automatic feed_b(input string tag);
    int guard;
    for (int e = 0; e < b_vals.size(); e++) begin
      b_data = b_vals[e];
      b_valid = 1'b1;
      guard = 0;
      while (!b_ready && guard < 200) begin @(negedge clk); guard++; end
      if (!b_ready) begin check({tag, "_b_ready_timeout"}, AW'(b_ready), 1); break; end
      @(negedge clk);
    end
    b_valid = 1'b0;
  endtask

  task automatic drain_c(input int m, input int k, input int n, input int stall_at,
                         input bit chk_lat, input string tag);
    int guard;
    logic [AW-1:0] held;
    c_ready = 1'b1;
    for (int e = 0; e < m * n; e++) begin
      guard = 0;
      while (!c_valid && guard < 200) begin @(negedge clk); guard++; end
      if (!c_valid) begin check({tag, "_c_valid_timeout"}, AW'(c_valid), 1); return; end
      if (e == 0 && chk_lat) check({tag, "_latency"}, AW'(cyc - start_cyc), AW'(1 + m*k + n*k + k));
      if (e == stall_at) begin
        c_ready = 1'b0;
        held = c_data;
        repeat (5) begin
          @(negedge clk);
          check({tag, "_stall_data"}, c_data, held);
          check({tag, "_stall_valid"}, AW'(c_valid), 1);
        end
        c_ready = 1'b1;
      end
      if (exp_q.size() == 0) begin check({tag, "_unexpected_c"}, c_data, 'x); end
      else check($sformatf("%s_c%0d", tag, e), c_data, exp_q.pop_front());
      @(negedge clk);
    end
    check({tag, "_done"}, AW'(done), 1);
    check({tag, "_busy_after"}, AW'(busy), 0);
    check({tag, "_c_valid_after"}, AW'(c_valid), 0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, AW'(done), 0);
  endtask

  task automatic run_job(input int m, input int k, input int n, input bit sgn, input bit accum,
                         input int stall_at, input bit busy_start, input string tag);
    build_expected(m, k, n, sgn, accum);
    do_start(m, k, n, sgn, accum);
    if (busy_start) begin
      cfg_m = 8'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_start_no_err"}, AW'(cfg_error), 0);
      check({tag, "_busy_start_busy"}, AW'(busy), 1);
      check({tag, "_busy_start_loading"}, AW'(a_ready), 1);
    end
    feed_a(tag);
    feed_b(tag);
    drain_c(m, k, n, stall_at, !busy_start, tag);
  endtask

  task automatic bad_start(input int m, input int k, input int n, input string tag);
    cfg_m = 8'(m); cfg_k = 8'(k); cfg_n = 8'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_cfg_error"}, AW'(cfg_error), 1);
    check({tag, "_busy"}, AW'(busy), 0);
    check({tag, "_a_ready"}, AW'(a_ready), 0);
    @(negedge clk);
    check({tag, "_cfg_error_pulse"}, AW'(cfg_error), 0);
    check({tag, "_still_idle"}, AW'(busy), 0);
  endtask

  initial begin
    logic seen_done;
    rst_n = 1'b0; start = 1'b0;
    cfg_m = '0; cfg_k = '0; cfg_n = '0; cfg_signed = 1'b0; cfg_accumulate = 1'b0;
    a_valid = 1'b0; a_data = '0; b_valid = 1'b0; b_data = '0; c_ready = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("idle");

    a_vals = '{8'd1, 8'd2, 8'd3, 8'd4};
    b_vals = '{8'd5, 8'd6, 8'd7, 8'd8};
    run_job(2, 2, 2, 1'b1, 1'b0, -1, 1'b0, "mm2x2");

    a_vals = '{8'd5, 8'd6, 8'd7, 8'd8};
    b_vals = '{8'd1, 8'd0, 8'd0, 8'd1};
    run_job(2, 2, 2, 1'b0, 1'b0, -1, 1'b0, "ident");

    a_vals.delete(); b_vals.delete();
    for (int e = 0; e < 16; e++) begin a_vals.push_back(8'd1); b_vals.push_back(8'd1); end
    run_job(4, 4, 4, 1'b0, 1'b0, 5, 1'b0, "ones4x4_stall");

    a_vals = '{8'hFF}; b_vals = '{8'h02};
    run_job(1, 1, 1, 1'b1, 1'b0, -1, 1'b0, "sgn_ff");
    run_job(1, 1, 1, 1'b0, 1'b0, -1, 1'b0, "uns_ff");

    a_vals = '{8'd3}; b_vals = '{8'd4};
    run_job(1, 1, 1, 1'b0, 1'b0, -1, 1'b0, "acc_first");
    a_vals = '{8'd2}; b_vals = '{8'd5};
    run_job(1, 1, 1, 1'b0, 1'b1, -1, 1'b0, "acc_second");

    a_vals = '{8'd7}; b_vals = '{8'd7};
    run_job(1, 1, 1, 1'b0, 1'b0, -1, 1'b0, "seven_sq");

    bad_start(0, 1, 1, "cfg_m0");
    bad_start(1, 1, 5, "cfg_n5");

    a_vals = '{8'd3}; b_vals = '{8'd3};
    run_job(1, 1, 1, 1'b0, 1'b0, -1, 1'b1, "busy_start");

    // Randomised rectangular signed job.
    a_vals.delete(); b_vals.delete();
    for (int e = 0; e < 3 * 4; e++) a_vals.push_back(8'($urandom_range(0, 255)));
    for (int e = 0; e < 4 * 2; e++) b_vals.push_back(8'($urandom_range(0, 255)));
    run_job(3, 4, 2, 1'b1, 1'b0, -1, 1'b0, "rand3x4x2");

    // Reset in the middle of LOAD_B.
    a_vals = '{8'd1, 8'd2, 8'd3, 8'd4};
    do_start(2, 2, 2, 1'b0, 1'b0);
    feed_a("rst_job");
    check("rst_job_in_load_b", AW'(b_ready), 1);
    b_valid = 1'b1; b_data = 8'd9;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("mid_reset");
    b_valid = 1'b0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (10) begin @(negedge clk); seen_done |= done; end
    check("mid_reset_no_done", AW'(seen_done), 0);
    check("mid_reset_idle", AW'(busy), 0);

    // Accumulators were cleared by reset, so accumulating starts from zero.
    a_vals = '{8'd1}; b_vals = '{8'd1};
    run_job(1, 1, 1, 1'b0, 1'b1, -1, 1'b0, "acc_after_reset");

    check("exp_q_empty", AW'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
